// File: rtl/mmu_bus_arbiter_if.sv
// mmu_bus_arbiter_if: CPU, OAM DMA, HDMA, MMU and HRAM signals of the bus arbiter.
// The arbiter connects through the master modport; the surrounding system uses slave.
interface mmu_bus_arbiter_if;
  logic [15:0] cpu_a;
  logic [7:0]  cpu_do;
  logic [7:0]  cpu_di;
  logic        cpu_wr;
  logic        cpu_rd;
  logic        cpu_stall;
  logic        dma_req;
  logic        dma_gnt;
  logic [15:0] dma_a;
  logic        dma_rd;
  logic [7:0]  dma_di;
  logic        hdma_req;
  logic        hdma_gnt;
  logic [15:0] hdma_a;
  logic [7:0]  hdma_do;
  logic        hdma_wr;
  logic        hdma_rd;
  logic [7:0]  hdma_di;
  logic [15:0] mmu_a;
  logic [7:0]  mmu_do;
  logic [7:0]  mmu_di;
  logic        mmu_wr;
  logic        mmu_rd;
  logic [6:0]  hram_a;
  logic [7:0]  hram_do;
  logic [7:0]  hram_di;
  logic        hram_wr;
  modport master (
    input  cpu_a, cpu_do, cpu_wr, cpu_rd,
    input  dma_req, dma_a, dma_rd,
    input  hdma_req, hdma_a, hdma_do, hdma_wr, hdma_rd,
    input  mmu_di, hram_di,
    output cpu_di, cpu_stall, dma_gnt, dma_di, hdma_gnt, hdma_di,
    output mmu_a, mmu_do, mmu_wr, mmu_rd, hram_a, hram_do, hram_wr
  );
  modport slave (
    output cpu_a, cpu_do, cpu_wr, cpu_rd,
    output dma_req, dma_a, dma_rd,
    output hdma_req, hdma_a, hdma_do, hdma_wr, hdma_rd,
    output mmu_di, hram_di,
    input  cpu_di, cpu_stall, dma_gnt, dma_di, hdma_gnt, hdma_di,
    input  mmu_a, mmu_do, mmu_wr, mmu_rd, hram_a, hram_do, hram_wr
  );
endinterface

// File: rtl/mmu_bus_arbiter.sv
// mmu_bus_arbiter: fixed-priority, non-preemptive MMU bus sharing between CPU, OAM DMA and HDMA,
// with an idle turnaround gap on every ownership change and a private always-on HRAM port.
module mmu_bus_arbiter #(
  parameter int          HANDOVER_CYCLES = 1,
  parameter logic [7:0]  OPEN_BUS        = 8'hFF
) (
  input logic clock,
  input logic reset_n,
  mmu_bus_arbiter_if.master bus
);
  typedef enum logic [1:0] {OWN_CPU, HANDOVER, OWN_DMA, OWN_HDMA} state_t;
  typedef enum logic [1:0] {T_CPU, T_DMA, T_HDMA} target_t;
  localparam logic [2:0] HO = 3'(HANDOVER_CYCLES);
  state_t      state, state_nx;
  target_t     target, target_nx, pick;
  logic [2:0]  cnt, cnt_nx;
  logic        from_hdma, from_hdma_nx;
  logic        live;
  logic [15:0] last_a;
  logic [7:0]  last_do;
  logic        is_hram, cpu_side, release_bus, target_req;
  function automatic state_t own(input target_t t);
    return t == T_DMA ? OWN_DMA : t == T_HDMA ? OWN_HDMA : OWN_CPU;
  endfunction
  // live masks every strobe until the first edge after reset release
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state     <= OWN_CPU;
      target    <= T_CPU;
      cnt       <= 3'd0;
      from_hdma <= 1'b0;
      live      <= 1'b0;
      last_a    <= 16'h0000;
      last_do   <= 8'h00;
    end else begin
      state     <= state_nx;
      target    <= target_nx;
      cnt       <= cnt_nx;
      from_hdma <= from_hdma_nx;
      live      <= 1'b1;
      last_a    <= bus.mmu_a;
      last_do   <= bus.mmu_do;
    end
  end
  always_comb begin
    state_nx     = state;
    target_nx    = target;
    cnt_nx       = cnt;
    from_hdma_nx = from_hdma;
    pick         = bus.dma_req ? T_DMA : bus.hdma_req ? T_HDMA : T_CPU;
    target_req   = target == T_DMA ? bus.dma_req : target == T_HDMA ? bus.hdma_req : 1'b1;
    release_bus  = (state == OWN_CPU  && pick != T_CPU) ||
                   (state == OWN_DMA  && !bus.dma_req) ||
                   (state == OWN_HDMA && !bus.hdma_req);
    if (release_bus) begin
      target_nx    = pick;
      from_hdma_nx = state == OWN_HDMA;
      cnt_nx       = HO;
      state_nx     = HO == 3'd0 ? own(pick) : HANDOVER;
    end else if (state == HANDOVER) begin
      cnt_nx = cnt - 3'd1;
      // a target that gave up its request during the gap loses its turn
      if (cnt <= 3'd1) state_nx = target_req ? own(target) : own(pick);
    end
  end
  always_comb begin
    is_hram      = (&bus.cpu_a[15:7]) && bus.cpu_a != 16'hFFFF;
    cpu_side     = live && state == OWN_CPU && !is_hram;
    bus.mmu_a    = cpu_side ? bus.cpu_a :
                   live && state == OWN_DMA  ? bus.dma_a :
                   live && state == OWN_HDMA ? bus.hdma_a : last_a;
    bus.mmu_do   = cpu_side ? bus.cpu_do : live && state == OWN_HDMA ? bus.hdma_do : last_do;
    bus.mmu_wr   = cpu_side ? bus.cpu_wr : live && state == OWN_HDMA && bus.hdma_wr;
    bus.mmu_rd   = cpu_side ? bus.cpu_rd :
                   live && state == OWN_DMA  ? bus.dma_rd :
                   live && state == OWN_HDMA && bus.hdma_rd;
  end
  assign bus.dma_gnt   = state == OWN_DMA;
  assign bus.hdma_gnt  = state == OWN_HDMA;
  assign bus.cpu_stall = state == OWN_HDMA || (state == HANDOVER && (target == T_HDMA || from_hdma));
  assign bus.dma_di    = bus.dma_gnt  ? bus.mmu_di : OPEN_BUS;
  assign bus.hdma_di   = bus.hdma_gnt ? bus.mmu_di : OPEN_BUS;
  assign bus.cpu_di    = is_hram ? bus.hram_di : state == OWN_CPU ? bus.mmu_di : OPEN_BUS;
  assign bus.hram_a    = bus.cpu_a[6:0];
  assign bus.hram_do   = bus.cpu_do;
  assign bus.hram_wr   = live && is_hram && bus.cpu_wr && !bus.cpu_stall;
endmodule

// File: tb/tb_mmu_bus_arbiter.sv
// tb_mmu_bus_arbiter: directed scenarios plus randomized traffic checked against an ownership model.
module tb_mmu_bus_arbiter;
  localparam int H = 1;
  localparam int CPU = 0, DMA = 1, HDMA = 2, GAP = 3;
  logic clock = 1'b0;
  logic reset_n = 1'b0;
  always #5 clock = ~clock;
  mmu_bus_arbiter_if bus();
  mmu_bus_arbiter #(.HANDOVER_CYCLES(H), .OPEN_BUS(8'hFF)) dut (.clock(clock), .reset_n(reset_n), .bus(bus));
  int n_checks = 0;
  int n_pass = 0;
  int owner, gap_left, gap_tgt;
  bit live, gap_from_hdma;
  logic [15:0] last_a, nxt_a;
  logic [7:0] last_do, nxt_do;
  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
  endtask
  task automatic model_reset();
    owner = CPU; gap_left = 0; gap_tgt = CPU; gap_from_hdma = 0; live = 0;
    last_a = 16'h0; last_do = 8'h0; nxt_a = 16'h0; nxt_do = 8'h0;
  endtask
  task automatic start_gap(input int t, input bit fh);
    if (H == 0) owner = t;
    else begin owner = GAP; gap_left = H; gap_tgt = t; gap_from_hdma = fh; end
  endtask
  task automatic step();
    int pick, keep;
    last_a = nxt_a; last_do = nxt_do;
    pick = bus.dma_req ? DMA : bus.hdma_req ? HDMA : CPU;
    case (owner)
      CPU:  if (pick != CPU) start_gap(pick, 0);
      DMA:  if (!bus.dma_req) start_gap(pick, 0);
      HDMA: if (!bus.hdma_req) start_gap(pick, 1);
      default: begin
        if (gap_left > 1) gap_left--;
        else begin
          keep = gap_tgt == DMA ? int'(bus.dma_req) : gap_tgt == HDMA ? int'(bus.hdma_req) : 1;
          owner = keep != 0 ? gap_tgt : pick;
        end
      end
    endcase
    live = 1;
  endtask
  task automatic compare_all();
    bit hram, cpu_bus, ewr, erd, stall;
    logic [15:0] ea;
    logic [7:0] edo;
    hram = bus.cpu_a >= 16'hFF80 && bus.cpu_a != 16'hFFFF;
    cpu_bus = live && owner == CPU && !hram;
    ea = last_a; edo = last_do; ewr = 0; erd = 0;
    if (cpu_bus) begin ea = bus.cpu_a; edo = bus.cpu_do; ewr = bus.cpu_wr; erd = bus.cpu_rd; end
    else if (live && owner == DMA) begin ea = bus.dma_a; erd = bus.dma_rd; end
    else if (live && owner == HDMA) begin ea = bus.hdma_a; edo = bus.hdma_do; ewr = bus.hdma_wr; erd = bus.hdma_rd; end
    stall = owner == HDMA || (owner == GAP && (gap_tgt == HDMA || gap_from_hdma));
    nxt_a = ea; nxt_do = edo;
    check("mmu_a", bus.mmu_a, ea);
    check("mmu_do", 16'(bus.mmu_do), 16'(edo));
    check("mmu_wr", 16'(bus.mmu_wr), 16'(ewr));
    check("mmu_rd", 16'(bus.mmu_rd), 16'(erd));
    check("dma_gnt", 16'(bus.dma_gnt), 16'(owner == DMA));
    check("hdma_gnt", 16'(bus.hdma_gnt), 16'(owner == HDMA));
    check("cpu_stall", 16'(bus.cpu_stall), 16'(stall));
    check("dma_di", 16'(bus.dma_di), 16'(owner == DMA ? bus.mmu_di : 8'hFF));
    check("hdma_di", 16'(bus.hdma_di), 16'(owner == HDMA ? bus.mmu_di : 8'hFF));
    check("cpu_di", 16'(bus.cpu_di), 16'(hram ? bus.hram_di : owner == CPU ? bus.mmu_di : 8'hFF));
    check("hram_a", 16'(bus.hram_a), 16'(bus.cpu_a & 16'h007F));
    check("hram_do", 16'(bus.hram_do), 16'(bus.cpu_do));
    check("hram_wr", 16'(bus.hram_wr), 16'(live && hram && bus.cpu_wr && !stall));
  endtask
  task automatic settle();
    @(negedge clock);
    compare_all();
  endtask
  task automatic tick();
    @(posedge clock);
    step();
    #1;
  endtask
  task automatic reset_pulse();
    #2 reset_n = 1'b0;
    #1;
    check("rst_dma_gnt", 16'(bus.dma_gnt), 16'h0);
    check("rst_hdma_gnt", 16'(bus.hdma_gnt), 16'h0);
    check("rst_mmu_wr", 16'(bus.mmu_wr), 16'h0);
    check("rst_mmu_rd", 16'(bus.mmu_rd), 16'h0);
    check("rst_cpu_stall", 16'(bus.cpu_stall), 16'h0);
    check("rst_hram_wr", 16'(bus.hram_wr), 16'h0);
    check("rst_mmu_a", bus.mmu_a, 16'h0);
    model_reset();
    @(posedge clock);
    #1 reset_n = 1'b1;
  endtask
  task automatic randomize_inputs();
    bus.cpu_a   = $urandom_range(0, 2) == 0 ? 16'hFF80 + 16'($urandom_range(0, 127)) : 16'($urandom);
    bus.cpu_do  = 8'($urandom);
    bus.cpu_wr  = 1'($urandom);
    bus.cpu_rd  = 1'($urandom);
    bus.dma_a   = 16'($urandom);
    bus.dma_rd  = 1'($urandom);
    bus.hdma_a  = 16'($urandom);
    bus.hdma_do = 8'($urandom);
    bus.hdma_wr = 1'($urandom);
    bus.hdma_rd = 1'($urandom);
    bus.mmu_di  = 8'($urandom);
    bus.hram_di = 8'($urandom);
    if ($urandom_range(0, 7) == 0) bus.dma_req = ~bus.dma_req;
    if ($urandom_range(0, 7) == 0) bus.hdma_req = ~bus.hdma_req;
  endtask
  initial begin
    {bus.cpu_a, bus.cpu_do, bus.cpu_wr, bus.cpu_rd} = '0;
    {bus.dma_req, bus.dma_a, bus.dma_rd} = '0;
    {bus.hdma_req, bus.hdma_a, bus.hdma_do, bus.hdma_wr, bus.hdma_rd} = '0;
    bus.mmu_di = 8'h00; bus.hram_di = 8'h00;
    model_reset();
    #12;
    compare_all();
    @(posedge clock);
    #1 reset_n = 1'b1;
    settle(); tick();
    bus.cpu_a = 16'hC000; bus.cpu_rd = 1'b1; bus.mmu_di = 8'h5A;
    settle();
    check("cpu_read_c000", 16'(bus.cpu_di), 16'h005A);
    check("cpu_read_strobe", 16'(bus.mmu_rd), 16'h1);
    tick();
    bus.dma_req = 1'b1; bus.dma_a = 16'hC100; bus.dma_rd = 1'b1; bus.cpu_rd = 1'b0;
    settle(); tick();
    settle();
    check("gap_mmu_rd", 16'(bus.mmu_rd), 16'h0);
    check("gap_dma_gnt", 16'(bus.dma_gnt), 16'h0);
    tick();
    bus.cpu_a = 16'hFF90; bus.cpu_do = 8'h33; bus.cpu_wr = 1'b1;
    settle();
    check("dma_gnt_up", 16'(bus.dma_gnt), 16'h1);
    check("dma_addr", bus.mmu_a, 16'hC100);
    check("hram_wr_in_dma", 16'(bus.hram_wr), 16'h1);
    check("hram_a_ff90", 16'(bus.hram_a), 16'h0010);
    check("mmu_wr_blocked", 16'(bus.mmu_wr), 16'h0);
    tick();
    bus.cpu_wr = 1'b0; bus.cpu_a = 16'hC000; bus.cpu_rd = 1'b1;
    settle();
    check("cpu_open_bus", 16'(bus.cpu_di), 16'h00FF);
    tick();
    bus.dma_req = 1'b0; bus.cpu_rd = 1'b0;
    settle(); tick(); settle(); tick();
    bus.dma_req = 1'b1; bus.hdma_req = 1'b1;
    settle(); tick();
    settle();
    check("both_gap_stall", 16'(bus.cpu_stall), 16'h0);
    tick();
    settle();
    check("both_dma_first", 16'(bus.dma_gnt), 16'h1);
    check("both_hdma_wait", 16'(bus.hdma_gnt), 16'h0);
    bus.dma_req = 1'b0;
    tick();
    settle();
    check("to_hdma_stall", 16'(bus.cpu_stall), 16'h1);
    check("to_hdma_gnt", 16'(bus.hdma_gnt), 16'h0);
    tick();
    settle();
    check("hdma_gnt_up", 16'(bus.hdma_gnt), 16'h1);
    check("hdma_stall", 16'(bus.cpu_stall), 16'h1);
    bus.dma_req = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick(); settle();
      check("no_preempt", 16'(bus.hdma_gnt), 16'h1);
    end
    bus.hdma_req = 1'b0;
    tick(); settle();
    check("leave_hdma_stall", 16'(bus.cpu_stall), 16'h1);
    tick(); settle();
    check("dma_after_hdma", 16'(bus.dma_gnt), 16'h1);
    bus.dma_req = 1'b0; bus.hdma_req = 1'b1; bus.hdma_wr = 1'b1; bus.hdma_a = 16'h8000;
    tick(); settle(); tick(); settle();
    check("hdma_wr_strobe", 16'(bus.mmu_wr), 16'h1);
    reset_pulse();
    settle();
    check("post_rst_hdma_gnt", 16'(bus.hdma_gnt), 16'h0);
    check("post_rst_stall", 16'(bus.cpu_stall), 16'h0);
    bus.hdma_req = 1'b0; bus.hdma_wr = 1'b0;
    tick();
    for (int i = 0; i < 3000; i++) begin
      randomize_inputs();
      settle();
      if (i % 600 == 300) reset_pulse();
      else tick();
    end
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
